// File: rtl/fft_stream_framer_pkg.sv
// Shared types and constants for the FFT stream framer.
// Config words follow the core's FWD_INV bit encoding.
package fft_pkg;

    typedef enum logic [1:0] {
        CFG,
        RUN,
        WAIT_EMPTY
    } state_t;

    localparam logic [7:0] CFG_FWD = 8'h01;
    localparam logic [7:0] CFG_INV = 8'h00;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/fft_stream_framer_if.sv
// Sample, config, data and event signals between framer and its peers.
// The master modport is the framer side.
interface fft_stream_framer_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic                inverse;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_re;
    logic [DATA_W-1:0]   in_im;
    logic [7:0]          cfg_tdata;
    logic                cfg_tvalid;
    logic                cfg_tready;
    logic [2*DATA_W-1:0] dat_tdata;
    logic                dat_tvalid;
    logic                dat_tready;
    logic                dat_tlast;
    logic                ev_tlast_unexpected;
    logic                ev_tlast_missing;
    logic [CNT_W-1:0]    cnt_unexpected;
    logic [CNT_W-1:0]    cnt_missing;
    logic [15:0]         frame_count;
    logic                busy_cfg;

    modport master (
        input  inverse, in_valid, in_re, in_im,
        input  cfg_tready, dat_tready,
        input  ev_tlast_unexpected, ev_tlast_missing,
        output in_ready, cfg_tdata, cfg_tvalid,
        output dat_tdata, dat_tvalid, dat_tlast,
        output cnt_unexpected, cnt_missing,
        output frame_count, busy_cfg
    );

    modport slave (
        output inverse, in_valid, in_re, in_im,
        output cfg_tready, dat_tready,
        output ev_tlast_unexpected, ev_tlast_missing,
        input  in_ready, cfg_tdata, cfg_tvalid,
        input  dat_tdata, dat_tvalid, dat_tlast,
        input  cnt_unexpected, cnt_missing,
        input  frame_count, busy_cfg
    );
endinterface

// File: rtl/fft_skid_buf.sv
// Two-entry valid/ready register slice; head entry drives the output,
// so data stays stable while the sink stalls.
module fft_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         empty
);
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [1:0]   occ;
    logic         push;
    logic         pop;

    assign in_ready  = occ != 2'd2;
    assign out_valid = occ != 2'd0;
    assign empty     = occ == 2'd0;
    assign out_data  = head;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= in_data;
                    else             tail <= in_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fft_stream_framer.sv
// Feeds the FFT core: config word, buffered samples with frame tlast,
// boundary-only mode switching and saturating core event counters.
module fft_stream_framer
    import fft_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 8
) (
    input logic              clock,
    input logic              fft_resetn,
    fft_stream_framer_if.master bus
);
    localparam int IDX_W = log2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nx;
    logic             started;
    logic             mode;
    logic [IDX_W-1:0] idx;
    logic [15:0]      frames;
    logic [CNT_W-1:0] cnt_u;
    logic [CNT_W-1:0] cnt_m;
    logic             in_rdy;
    logic             cfg_vld;
    logic             skid_ready;
    logic             skid_empty;
    logic             out_vld;
    logic             beat;
    logic             last_beat;
    logic             pending;
    logic             load_mode;

    fft_skid_buf #(.W(2 * DATA_W)) u_skid (
        .clk       (clock),
        .rst_n     (fft_resetn),
        .in_valid  (bus.in_valid & in_rdy),
        .in_ready  (skid_ready),
        .in_data   ({bus.in_im, bus.in_re}),
        .out_valid (out_vld),
        .out_ready (bus.dat_tready),
        .out_data  (bus.dat_tdata),
        .empty     (skid_empty)
    );

    assign pending   = bus.inverse != mode;
    assign beat      = out_vld & bus.dat_tready;
    assign last_beat = beat & (idx == LAST);

    always_comb begin
        state_nx = state;
        in_rdy   = 1'b0;
        cfg_vld  = 1'b0;
        unique case (state)
            CFG: begin
                cfg_vld = started;
                if (started && bus.cfg_tready) state_nx = RUN;
            end
            RUN: begin
                // Hold off next-frame samples so the buffer is empty at the switch.
                in_rdy = skid_ready & ~((idx == LAST) & pending);
                if (last_beat && pending) state_nx = WAIT_EMPTY;
            end
            WAIT_EMPTY: begin
                if (skid_empty) state_nx = CFG;
            end
            default: state_nx = CFG;
        endcase
    end

    assign load_mode = ~started | ((state == WAIT_EMPTY) & (state_nx == CFG));

    always_ff @(posedge clock or negedge fft_resetn) begin
        if (!fft_resetn) begin
            state   <= CFG;
            started <= 1'b0;
            mode    <= 1'b0;
            idx     <= '0;
            frames  <= 16'd0;
            cnt_u   <= '0;
            cnt_m   <= '0;
        end else begin
            state   <= state_nx;
            started <= 1'b1;
            if (load_mode) mode <= bus.inverse;
            if (beat) idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);
            if (last_beat) frames <= frames + 16'd1;
            if (bus.ev_tlast_unexpected && cnt_u != '1)
                cnt_u <= cnt_u + CNT_W'(1);
            if (bus.ev_tlast_missing && cnt_m != '1)
                cnt_m <= cnt_m + CNT_W'(1);
        end
    end

    assign bus.in_ready       = in_rdy;
    assign bus.cfg_tvalid     = cfg_vld;
    assign bus.cfg_tdata      = mode ? CFG_INV : CFG_FWD;
    assign bus.dat_tvalid     = out_vld;
    assign bus.dat_tlast      = (idx == LAST) & out_vld;
    assign bus.cnt_unexpected = cnt_u;
    assign bus.cnt_missing    = cnt_m;
    assign bus.frame_count    = frames;
    assign bus.busy_cfg       = state == CFG;
endmodule

// File: tb/tb_fft_stream_framer.sv
// Directed bench for fft_stream_framer with FRAME_LEN = 8:
// vector table for backpressure plus hand sequences for mode/reset.
module tb_fft_stream_framer;
    localparam int DW = 16;
    localparam int FL = 8;
    localparam int CW = 8;

    typedef struct packed {
        logic rdy;
        logic ir;
        logic tv;
        logic last;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_stream_framer_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    fft_stream_framer #(
        .DATA_W    (DW),
        .FRAME_LEN (FL),
        .CNT_W     (CW)
    ) dut (
        .clock      (clk),
        .fft_resetn (rst_n),
        .bus        (bus)
    );

    int nvec = 0;
    int nerr = 0;
    logic [31:0] exp_q[$];
    int out_pos = 0;
    int n_out = 0;
    int n_tl = 0;
    int next_in = 0;
    logic obs_ir, obs_tv, obs_last, obs_tl_hs;
    logic [7:0] obs_cfgd;
    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic vld);
        bus.dat_tready = rdy;
        bus.in_valid   = vld;
        bus.in_re      = next_in[15:0];
        bus.in_im      = next_in[15:0] + 16'h0100;
        @(negedge clk);
        obs_ir    = bus.in_ready;
        obs_tv    = bus.dat_tvalid;
        obs_last  = bus.dat_tlast;
        obs_cfgd  = bus.cfg_tdata;
        obs_tl_hs = 1'b0;
        if (bus.dat_tvalid && rdy) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL spurious_out: got %0h want none", bus.dat_tdata);
            end else begin
                chk("data", bus.dat_tdata, exp_q.pop_front());
            end
            chk("tlast", 32'(bus.dat_tlast), 32'(out_pos == FL - 1));
            obs_tl_hs = bus.dat_tlast;
            if (bus.dat_tlast) n_tl++;
            out_pos = (out_pos + 1) % FL;
            n_out++;
        end
        if (vld && bus.in_ready) begin
            exp_q.push_back({bus.in_im, bus.in_re});
            next_in++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mcheck(input string tag, input logic busy, input logic cfgv,
                          input logic [7:0] cfgd, input logic ir, input logic tv);
        bus.in_valid   = 1'b0;
        bus.dat_tready = 1'b1;
        @(negedge clk);
        chk({tag, "_busy"}, 32'(bus.busy_cfg), 32'(busy));
        chk({tag, "_cfgv"}, 32'(bus.cfg_tvalid), 32'(cfgv));
        chk({tag, "_cfgd"}, 32'(bus.cfg_tdata), 32'(cfgd));
        chk({tag, "_ir"}, 32'(bus.in_ready), 32'(ir));
        chk({tag, "_tv"}, 32'(bus.dat_tvalid), 32'(tv));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cfgv"}, 32'(bus.cfg_tvalid), 32'd0);
        chk({tag, "_tv"}, 32'(bus.dat_tvalid), 32'd0);
        chk({tag, "_tl"}, 32'(bus.dat_tlast), 32'd0);
        chk({tag, "_ir"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_cu"}, 32'(bus.cnt_unexpected), 32'd0);
        chk({tag, "_cm"}, 32'(bus.cnt_missing), 32'd0);
        chk({tag, "_fc"}, 32'(bus.frame_count), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy_cfg), 32'd1);
        chk({tag, "_cfgd"}, 32'(bus.cfg_tdata), 32'h01);
    endtask

    task automatic release_and_cfg(input string tag, input logic [7:0] cfgd);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mcheck({tag, "_c1"}, 1'b1, 1'b1, cfgd, 1'b0, 1'b0);
        mcheck({tag, "_c2"}, 1'b0, 1'b0, cfgd, 1'b1, 1'b0);
    endtask

    task automatic stream(input int n);
        int lim;
        int goal;
        lim  = next_in + n;
        goal = n_out + n;
        for (int c = 0; c < 4 * n + 10 && n_out < goal; c++)
            step(1'b1, 32'(next_in) < 32'(lim));
        chk("stream_cnt", 32'(n_out), 32'(goal));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int tl0;
        // {dat_tready, in_ready, dat_tvalid, dat_tlast} per cycle
        tbl[0]  = 4'b0100; tbl[1]  = 4'b1110;
        tbl[2]  = 4'b0110; tbl[3]  = 4'b1010;
        tbl[4]  = 4'b0110; tbl[5]  = 4'b1010;
        tbl[6]  = 4'b0110; tbl[7]  = 4'b1010;
        tbl[8]  = 4'b0110; tbl[9]  = 4'b1010;
        tbl[10] = 4'b0110; tbl[11] = 4'b1010;
        tbl[12] = 4'b0110; tbl[13] = 4'b1010;
        tbl[14] = 4'b0111; tbl[15] = 4'b1011;

        bus.inverse = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_re = '0;
        bus.in_im = '0;
        bus.cfg_tready = 1'b1;
        bus.dat_tready = 1'b0;
        bus.ev_tlast_unexpected = 1'b0;
        bus.ev_tlast_missing = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        release_and_cfg("boot", 8'h01);

        stream(24);
        chk("s24_tl", 32'(n_tl), 32'd3);
        chk("s24_fc", 32'(bus.frame_count), 32'd3);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rdy, 1'b1);
            chk($sformatf("tog%0d_ir", i), 32'(obs_ir), 32'(tbl[i].ir));
            chk($sformatf("tog%0d_tv", i), 32'(obs_tv), 32'(tbl[i].tv));
            chk($sformatf("tog%0d_tl", i), 32'(obs_last), 32'(tbl[i].last));
        end
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) step(1'b1, 1'b0);
        chk("tog_drain", 32'(exp_q.size()), 32'd0);
        chk("tog_fc", 32'(bus.frame_count), 32'd4);

        for (int c = 0; c < 40; c++) begin
            if (out_pos == 3) bus.inverse = 1'b1;
            step(1'b1, 1'b1);
            if (obs_tl_hs) break;
        end
        chk("mc_tlast", 32'(obs_tl_hs), 32'd1);
        chk("mc_blk_ir", 32'(obs_ir), 32'd0);
        chk("mc_fwd", 32'(obs_cfgd), 32'h01);
        mcheck("mc_wait", 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
        mcheck("mc_cfg", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        mcheck("mc_run", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tl0 = n_tl;
        stream(8);
        chk("mc_tl8", 32'(n_tl - tl0), 32'd1);
        chk("mc_fc", 32'(bus.frame_count), 32'd6);

        for (int i = 0; i < 3; i++) begin
            bus.ev_tlast_unexpected = 1'b1;
            bus.ev_tlast_missing = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.ev_tlast_unexpected = 1'b0;
        chk("ev_both_u", 32'(bus.cnt_unexpected), 32'd3);
        chk("ev_both_m", 32'(bus.cnt_missing), 32'd3);
        for (int i = 0; i < 297; i++) begin
            @(posedge clk);
            #1;
        end
        bus.ev_tlast_missing = 1'b0;
        chk("ev_sat_m", 32'(bus.cnt_missing), 32'd255);
        chk("ev_sat_u", 32'(bus.cnt_unexpected), 32'd3);

        for (int c = 0; c < 20 && out_pos != 5; c++) step(1'b1, 1'b1);
        chk("mid_pos", 32'(out_pos), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mid");
        exp_q.delete();
        out_pos = 0;
        release_and_cfg("rel", 8'h00);
        tl0 = n_tl;
        stream(8);
        chk("rel_tl8", 32'(n_tl - tl0), 32'd1);
        chk("rel_fc", 32'(bus.frame_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fft_stream_framer.md
# fft_stream_framer

Parametrised front-end that feeds complex samples into the vendor FFT core over AXI-Stream. It issues the core's configuration word, registers the sample path through a skid buffer, and asserts tlast on every FRAME_LEN-th sample. Forward/inverse mode switches only at frame boundaries, and the core's error events are counted. It sits between the sample source and the FFT core instance, replacing hand-wired constant config/tvalid ties.

## Interface
- DATA_W, 16: width of each of re/im; core data word is 2*DATA_W.
- FRAME_LEN, 64: samples per frame; power of two, 8..65536.
- CNT_W, 8: width of each saturating event counter.
- clock  in  1  single clock for all logic.
- fft_resetn  in  1  asynchronous, active-low reset.
- inverse  in  1  requested mode: 0 = forward, 1 = inverse; sampled only at frame boundaries.
- in_valid / in_ready  in / out  1  upstream sample handshake.
- in_re, in_im  in  DATA_W  upstream sample.
- cfg_tdata  out  8  core config word: bits[7:1] = 0, bit0 = 1 for forward, 0 for inverse.
- cfg_tvalid / cfg_tready  out / in  1  core config handshake.
- dat_tdata  out  2*DATA_W  {im, re} to core.
- dat_tvalid / dat_tready  out / in  1  core data handshake.
- dat_tlast  out  1  high on the last sample of each frame.
- ev_tlast_unexpected, ev_tlast_missing  in  1  core event pulses.
- cnt_unexpected, cnt_missing  out  CNT_W  saturating event counts.
- frame_count  out  16  frames completed, wraps.
- busy_cfg  out  1  high while in CFG state.

## Operation
- FSM states: CFG, RUN, WAIT_EMPTY.
- CFG:
  - cfg_tvalid = 1 with the mode latched on entry.
  - Leave to RUN on the cycle after cfg_tvalid & cfg_tready.
  - in_ready = 0.
- RUN:
  - Samples pass through the 2-entry skid buffer; in_ready = buffer not full.
  - Sample counter increments on each dat_tvalid & dat_tready and wraps at FRAME_LEN-1 → 0.
  - dat_tlast = (counter == FRAME_LEN-1) & dat_tvalid.
  - On the tlast beat, frame_count increments. If inverse differs from the latched mode, go to WAIT_EMPTY.
- WAIT_EMPTY:
  - in_ready = 0.
  - Stay until the skid buffer is empty, then go to CFG. Samples already accepted belong to the next frame and are held until after reconfiguration.
- Because WAIT_EMPTY needs the buffer to drain, its entries must be emitted without sending a new frame. Therefore in_ready is forced to 0 while the counter is FRAME_LEN-1 with a pending mode change. The buffer is then empty at the boundary, and WAIT_EMPTY lasts exactly 1 cycle.
- Event counters increment on each input pulse and saturate at 2^CNT_W-1. Both pulses in the same cycle increment both counters.
- Reset state: CFG with mode = inverse sampled at reset release. Outputs at reset: cfg_tvalid 0, dat_tvalid 0, dat_tlast 0, in_ready 0, counters 0, frame_count 0, busy_cfg 1, cfg_tdata 8'h01.
- Reset asserted mid-frame discards the buffer and the counter. The next frame starts at sample 0 after reconfiguration.

## Timing
- cfg_tvalid rises on the first clock after fft_resetn deasserts.
- Skid-buffer latency is 1 cycle from an input handshake to dat_tvalid.
- Full throughput is 1 sample/cycle with dat_tready held high. A dat_tready drop absorbs at most 2 samples, and in_ready falls in the same cycle the buffer becomes full.
- dat_tdata and dat_tlast stay stable while dat_tvalid & !dat_tready.
- Mode change costs 2 cycles with cfg_tready high: WAIT_EMPTY, then CFG. In the CFG cycle, cfg_tvalid = cfg_tready = 1.

## Structure
- fft_pkg holds:
  - state enum (CFG, RUN, WAIT_EMPTY);
  - CFG_FWD = 8'h01 and CFG_INV = 8'h00;
  - the log2 helper for counter width.
- Natural sub-module: fft_skid_buf, a parametrised-width, 2-entry valid/ready register slice. The framer instantiates it on {im, re}.

## Test plan
- Reset release with cfg_tready = 1 and inverse = 0 → cfg_tdata 8'h01 accepted on cycle 1, busy_cfg falls, in_ready = 1 on cycle 2.
- FRAME_LEN = 8, 24 back-to-back samples, dat_tready = 1 → dat_tlast on outputs 8, 16 and 24; frame_count = 3; data order preserved.
- dat_tready toggled on alternate cycles → no sample lost or duplicated; in_ready low only while 2 entries are held.
- inverse raised mid-frame at sample 3 → remaining samples of the frame are in forward mode; cfg_tdata 8'h00 handshaked after the tlast beat; next frame counter starts at 0.
- ev_tlast_missing pulsed 300 times with CNT_W = 8 → cnt_missing = 255. Simultaneous pulses increment both counters.
- fft_resetn asserted at sample 5 → all outputs return to reset values immediately; after release, the first tlast is on the 8th new sample.
